// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: sequencer state
// encoding, writeback-source codes and PC-source codes.
package cpu_pkg;

  // Sequencer state, 3-bit encoding exported on state_o for debug
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } seq_state_t;

  // Writeback source select (WBSrc from opcode_decoder)
  localparam logic [2:0] WB_MEM  = 3'b000;
  localparam logic [2:0] WB_ALU  = 3'b001;
  localparam logic [2:0] WB_PC2  = 3'b010;
  localparam logic [2:0] WB_RY   = 3'b011;
  localparam logic [2:0] WB_IMM8 = 3'b100;

  // PC source select
  localparam logic [1:0] PC_INC2 = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_RY   = 2'b11;

  // Loads and stores are the only instructions that visit the MEM state
  function automatic logic is_mem_access(input logic       reg_write,
                                         input logic       mem_write,
                                         input logic [2:0] wb_src);
    return mem_write | (reg_write & (wb_src == WB_MEM));
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait counter with timeout compare. Counts cycles spent waiting on
// mem_ready; expired is raised in the cycle the count reaches MEM_WAIT_MAX
// while still waiting, so the caller can divert to its fault state.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  logic [CW-1:0] r_cnt;

  // Wait counter: clear has priority, otherwise advance while waiting
  always_ff @(posedge clk) begin
    if (reset || clear)
      r_cnt <= '0;
    else if (count)
      r_cnt <= r_cnt + CW'(1);
  end

  assign expired = count && (r_cnt == CW'(MEM_WAIT_MAX));

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a
// shared memory port, a wait timeout into a sticky FAULT state and a halt
// handshake at instruction boundaries. Outputs are decoded from state and
// inputs and forced to 0 while reset is high.
// Optional: define CPU_SEQ_PERF_EN to add cycle_cnt / instr_cnt counters.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_reg_write,
  input  logic        dec_mem_write,
  input  logic [2:0]  dec_wb_src,
  input  logic        dec_nz,
  input  logic        dec_pc_enable,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        mem_re,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_load,
  output logic        rf_we,
  output logic        nz_we,
  output logic        pc_we,
  output logic        halted,
  output logic        fault,
`ifdef CPU_SEQ_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  output logic [2:0]  state_o
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic       w_wait;
  logic       w_expired;
  logic       w_run;

  assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_run  = ~reset;

  // Counter is held clear outside the wait states, so it is zero on entry
  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~w_wait | mem_ready),
    .count   (w_wait & ~mem_ready),
    .expired (w_expired)
  );

  // Next-state decode; mem_ready wins over a simultaneous timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
                else if (w_expired) w_next = S_FAULT;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = is_mem_access(dec_reg_write, dec_mem_write, dec_wb_src)
                         ? S_MEM : S_WB;
      S_MEM:    if (mem_ready) w_next = S_WB;
                else if (w_expired) w_next = S_FAULT;
      S_WB:     w_next = halt_req ? S_HALT : S_FETCH;
      S_HALT:   w_next = halt_req ? S_HALT : S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
  end

  // State register; reset always restarts at FETCH
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_FETCH;
    else
      r_state <= w_next;
  end

  // Output strobes, all suppressed during reset so an aborted instruction
  // never commits
  always_comb begin
    mem_re  = w_run & ((r_state == S_FETCH) | ((r_state == S_MEM) & ~dec_mem_write));
    mem_we  = w_run & (r_state == S_MEM) & dec_mem_write;
    mem_sel = w_run & (r_state == S_MEM);
    ir_load = w_run & (r_state == S_FETCH) & mem_ready;
    rf_we   = w_run & (r_state == S_WB) & dec_reg_write;
    nz_we   = w_run & (r_state == S_WB) & dec_nz;
    pc_we   = w_run & (r_state == S_WB) & dec_pc_enable;
    halted  = w_run & (r_state == S_HALT);
    fault   = w_run & (r_state == S_FAULT);
    state_o = w_run ? r_state : 3'd0;
  end

`ifdef CPU_SEQ_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // Performance counters: active cycles and retired instructions (WB)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if ((r_state != S_HALT) && (r_state != S_FAULT))
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_state == S_WB)
        r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule
